// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the program counter, fetches one word per
// PC load over a req/ack memory handshake of arbitrary latency, and holds
// the fetched word valid until CONTROL commands the next load. A sticky
// error flag reports a memory that fails to acknowledge in time.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Reset,
    input  logic        PC_sel,
    input  logic        PC_LdEn,
    input  logic [31:0] PC_Immed,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] PC,
    output logic        Fetch_err
);

    // Last count value before the timeout fires; counter is wide enough
    // for the full 2..255 range of ACK_TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  ack_cnt;
    logic        capture;
    logic        load;
    logic        timeout_hit;
    logic [31:0] pc_next;

    // Sequential or branch target; all arithmetic wraps modulo 2^32 and the
    // shift drops the top two bits of the word offset.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic        sel,
                                            input logic [31:0] immed);
        logic [31:0] offset;
        offset = sel ? (immed << 2) : 32'd0;
        return pc + 32'd4 + offset;
    endfunction

    assign pc_next   = next_pc(PC, PC_sel, PC_Immed);
    assign Imem_req  = (state == REQ);
    assign Imem_addr = PC;

    // Next-state decode plus the one-cycle event strobes for the datapath;
    // soft reset overrides every other event in the same cycle.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        load        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (Imem_ack) begin
                    capture    = 1'b1;
                    state_next = READY;
                end else if (ack_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                end
            end
            READY: begin
                if (PC_LdEn) begin
                    load       = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (Reset) begin
            state_next  = IDLE;
            capture     = 1'b0;
            load        = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    // State register; asynchronous reset lands in IDLE immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, fetched word, valid flag, timeout counter and sticky error.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            Instr_valid <= 1'b0;
            Fetch_err   <= 1'b0;
            ack_cnt     <= 8'd0;
        end else if (Reset) begin
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            Instr_valid <= 1'b0;
            Fetch_err   <= 1'b0;
            ack_cnt     <= 8'd0;
        end else begin
            if (load) begin
                PC          <= pc_next;
                Instr_valid <= 1'b0;
            end
            if (capture) begin
                Instr       <= Imem_rdata;
                Instr_valid <= 1'b1;
            end
            if (state == REQ) begin
                if (capture || timeout_hit) begin
                    ack_cnt <= 8'd0;
                end else begin
                    ack_cnt <= ack_cnt + 8'd1;
                end
            end
            if (timeout_hit) begin
                Fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: a behavioural memory answers fetch
// requests after a programmable number of wait cycles, expected PC/word
// pairs are queued on each PC load and popped when Instr_valid rises.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 16;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Reset = 1'b0;
    logic        PC_sel = 1'b0;
    logic        PC_LdEn = 1'b0;
    logic [31:0] PC_Immed = 32'd0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack = 1'b0;
    logic [31:0] Imem_rdata = 32'd0;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;
    logic        Fetch_err;

    int total = 0;
    int bad   = 0;

    int mem_lat   = 0;
    bit ack_force = 1'b0;
    int req_cnt   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    if_fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Reset(Reset),
        .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .PC_Immed(PC_Immed),
        .Imem_req(Imem_req), .Imem_addr(Imem_addr),
        .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
        .Instr(Instr), .Instr_valid(Instr_valid),
        .PC(PC), .Fetch_err(Fetch_err)
    );

    initial forever #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h80C7_2831;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: acks on REQ cycle number mem_lat (0 = first cycle).
    initial forever begin
        @(negedge Clk);
        if (ack_force) begin
            Imem_ack   = 1'b1;
            Imem_rdata = 32'h0BAD_0BAD;
        end else if (Imem_req) begin
            if (req_cnt == mem_lat) begin
                Imem_ack   = 1'b1;
                Imem_rdata = mem_word(Imem_addr);
            end else begin
                Imem_ack   = 1'b0;
                Imem_rdata = 32'hDEAD_BEEF;
            end
            req_cnt++;
        end else begin
            Imem_ack = 1'b0;
            req_cnt  = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) tick();
        total++; if (PC !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, RST_PC); end
        total++; if (Instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", Instr); end
        total++; if ({Instr_valid, Imem_req, Fetch_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {Instr_valid, Imem_req, Fetch_err}); end
        mem_lat = 0;
        sb.push_back('{RST_PC, 32'h80C7_2831});
        Reset_n = 1'b1;
        tick();
        total++; if ({Imem_req, Instr_valid} !== 2'b10) begin bad++; $display("FAIL edge1_req got=%b exp=10", {Imem_req, Instr_valid}); end
        tick();
        total++; if (Instr_valid !== 1'b1) begin bad++; $display("FAIL edge2_valid got=%b exp=1", Instr_valid); end
        e = sb.pop_front();
        total++; if (PC !== e.pc) begin bad++; $display("FAIL first_pc got=%h exp=%h", PC, e.pc); end
        total++; if (Instr !== e.instr) begin bad++; $display("FAIL first_instr got=%h exp=%h", Instr, e.instr); end
        total++; if ({Fetch_err, Imem_req} !== 2'b00) begin bad++; $display("FAIL first_err_req got=%b exp=00", {Fetch_err, Imem_req}); end
    endtask

    // Accept one PC load in READY and track the fetch to completion.
    task automatic do_load(input logic sel, input logic [31:0] imm,
                           input int lat, input logic [31:0] exp_pc);
        exp_t e;
        int   n;
        mem_lat = lat;
        sb.push_back('{exp_pc, mem_word(exp_pc)});
        PC_sel   = sel;
        PC_Immed = imm;
        PC_LdEn  = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        total++; if (Instr_valid !== 1'b0) begin bad++; $display("FAIL ld_valid_fall pc=%h got=%b exp=0", exp_pc, Instr_valid); end
        total++; if (PC !== exp_pc) begin bad++; $display("FAIL ld_pc got=%h exp=%h", PC, exp_pc); end
        total++; if (Imem_req !== 1'b1 || Imem_addr !== exp_pc) begin bad++; $display("FAIL ld_req got=%b/%h exp=1/%h", Imem_req, Imem_addr, exp_pc); end
        n = 0;
        while (!Instr_valid && n < 64) begin
            tick();
            n++;
        end
        total++; if (n !== lat + 1) begin bad++; $display("FAIL ld_latency pc=%h got=%0d exp=%0d", exp_pc, n, lat + 1); end
        e = sb.pop_front();
        total++; if (PC !== e.pc || Instr !== e.instr) begin bad++; $display("FAIL ld_result got=%h/%h exp=%h/%h", PC, Instr, e.pc, e.instr); end
    endtask

    task automatic test_sequential();
        do_load(1'b0, 32'd0, 0, 32'h04);
        do_load(1'b0, 32'd0, 1, 32'h08);
        do_load(1'b0, 32'd0, 0, 32'h0C);
        do_load(1'b0, 32'd0, 3, 32'h10);
        do_load(1'b0, 32'd0, 2, 32'h14);
    endtask

    task automatic test_branch_wrap();
        do_load(1'b1, 32'h4000_0002, 0, 32'h20);
        do_load(1'b1, 32'hFFFF_FFF8, 1, 32'h04);
        do_load(1'b1, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFC);
        do_load(1'b0, 32'h1234_5678, 0, 32'h0000_0000);
    endtask

    task automatic test_ack_outside_req();
        logic [31:0] held;
        held = Instr;
        ack_force = 1'b1;
        repeat (2) tick();
        ack_force = 1'b0;
        tick();
        total++; if (Instr !== held || Instr_valid !== 1'b1) begin bad++; $display("FAIL ack_outside got=%h/%b exp=%h/1", Instr, Instr_valid, held); end
    endtask

    task automatic test_ldEn_in_req();
        exp_t e;
        int   n;
        mem_lat = 3;
        sb.push_back('{32'h04, mem_word(32'h04)});
        PC_sel  = 1'b0;
        PC_LdEn = 1'b1;
        tick();
        PC_sel   = 1'b1;
        PC_Immed = 32'd100;
        tick();
        total++; if (PC !== 32'h04) begin bad++; $display("FAIL ld_in_req_1 got=%h exp=00000004", PC); end
        tick();
        total++; if (PC !== 32'h04) begin bad++; $display("FAIL ld_in_req_2 got=%h exp=00000004", PC); end
        PC_LdEn = 1'b0;
        n = 2;
        while (!Instr_valid && n < 64) begin
            tick();
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL ld_in_req_lat got=%0d exp=4", n); end
        e = sb.pop_front();
        total++; if (PC !== e.pc || Instr !== e.instr) begin bad++; $display("FAIL ld_in_req_result got=%h/%h exp=%h/%h", PC, Instr, e.pc, e.instr); end
    endtask

    task automatic test_timeout();
        int first_err   = 0;
        int first_valid = 0;
        bit req_at_err  = 1'b0;
        exp_t e;
        mem_lat = 19;
        sb.push_back('{32'h08, mem_word(32'h08)});
        PC_sel  = 1'b0;
        PC_LdEn = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (Fetch_err && first_err == 0) begin
                first_err  = k;
                req_at_err = Imem_req;
            end
            if (Instr_valid) begin
                first_valid = k;
                break;
            end
        end
        total++; if (first_err !== TMO) begin bad++; $display("FAIL timeout_edge got=%0d exp=%0d", first_err, TMO); end
        total++; if (req_at_err !== 1'b1) begin bad++; $display("FAIL timeout_req got=%b exp=1", req_at_err); end
        total++; if (first_valid !== 20) begin bad++; $display("FAIL late_ack_edge got=%0d exp=20", first_valid); end
        e = sb.pop_front();
        total++; if (Instr !== e.instr || PC !== e.pc) begin bad++; $display("FAIL late_ack_word got=%h/%h exp=%h/%h", PC, Instr, e.pc, e.instr); end
        repeat (3) tick();
        total++; if (Fetch_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", Fetch_err); end
    endtask

    task automatic test_sync_reset();
        mem_lat = 0;
        PC_sel  = 1'b0;
        PC_LdEn = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        Reset   = 1'b1;
        tick();
        Reset = 1'b0;
        total++; if (PC !== RST_PC || Instr !== 32'd0) begin bad++; $display("FAIL srst_vals got=%h/%h exp=%h/0", PC, Instr, RST_PC); end
        total++; if ({Instr_valid, Imem_req, Fetch_err} !== 3'b000) begin bad++; $display("FAIL srst_flags got=%b exp=000", {Instr_valid, Imem_req, Fetch_err}); end
        tick();
        total++; if (Imem_req !== 1'b1) begin bad++; $display("FAIL srst_restart_req got=%b exp=1", Imem_req); end
        tick();
        total++; if (Instr_valid !== 1'b1 || Instr !== 32'h80C7_2831) begin bad++; $display("FAIL srst_refetch got=%b/%h exp=1/80c72831", Instr_valid, Instr); end
        PC_LdEn = 1'b1;
        Reset   = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        Reset   = 1'b0;
        total++; if (PC !== RST_PC || Instr_valid !== 1'b0) begin bad++; $display("FAIL srst_over_ld got=%h/%b exp=%h/0", PC, Instr_valid, RST_PC); end
        repeat (2) tick();
        total++; if (Instr_valid !== 1'b1) begin bad++; $display("FAIL srst_over_ld_refetch got=%b exp=1", Instr_valid); end
    endtask

    task automatic test_async_reset();
        mem_lat = 5;
        PC_sel  = 1'b0;
        PC_LdEn = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        total++; if ({Imem_req, Instr_valid} !== 2'b00) begin bad++; $display("FAIL arst_immediate got=%b exp=00", {Imem_req, Instr_valid}); end
        total++; if (PC !== RST_PC) begin bad++; $display("FAIL arst_pc got=%h exp=%h", PC, RST_PC); end
        mem_lat = 0;
        tick();
        Reset_n = 1'b1;
        tick();
        total++; if (Imem_req !== 1'b1 || Imem_addr !== RST_PC) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/%h", Imem_req, Imem_addr, RST_PC); end
        tick();
        total++; if (Instr_valid !== 1'b1 || Instr !== 32'h80C7_2831) begin bad++; $display("FAIL arst_refetch got=%b/%h exp=1/80c72831", Instr_valid, Instr); end
    endtask

    task automatic test_back_to_back();
        do_load(1'b0, 32'd0, 0, 32'h04);
        do_load(1'b1, 32'h0000_0010, 0, 32'h48);
        do_load(1'b1, 32'hFFFF_FFEE, 1, 32'h04);
        do_load(1'b0, 32'd0, 0, 32'h08);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_wrap();
        test_ack_outside_req();
        test_ldEn_in_req();
        test_timeout();
        test_sync_reset();
        test_async_reset();
        test_back_to_back();
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
